// File: rtl/univ_reg_pkg.sv
// Mode encodings for the universal register, shared with the CPU control decoder.
package univ_reg_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_INC  = 3'b100;
    localparam logic [2:0] MODE_DEC  = 3'b101;
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_ROR  = 3'b111;
endpackage

// File: rtl/univ_reg.sv
// Universal register: load, shift, rotate, up/down count with terminal count
// and a sticky wrap flag, all gated by an active-low enable.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_lsb_in,
    input  logic             ser_msb_in,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] RST_V    = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (!en_n) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: begin
                    q_d    = d;
                    wrap_d = 1'b0;
                end
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_lsb_in};
                MODE_SHR:  q_d = {ser_msb_in, q_q[WIDTH-1:1]};
                MODE_INC: begin
                    q_d = q_q + ONE;
                    if (q_q == ALL_ONES) wrap_d = 1'b1;
                end
                MODE_DEC: begin
                    q_d = q_q - ONE;
                    if (q_q == ZERO) wrap_d = 1'b1;
                end
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_V;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // tc looks ahead one edge so a following stage can use ~tc as its en_n.
    assign tc   = ~en_n & (((mode == MODE_INC) & (q_q == ALL_ONES)) |
                           ((mode == MODE_DEC) & (q_q == ZERO)));
    assign q    = q_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_univ_reg.sv
// Directed testbench for univ_reg: reset, load/enable, shift/rotate, count wrap,
// two-stage cascade and reset during counting.
module tb_univ_reg;
    import univ_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_n = 1'b1;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic       ser_lsb_in = 1'b0;
    logic       ser_msb_in = 1'b0;
    logic [7:0] q;
    logic       tc;
    logic       wrap;

    logic       casc_rst = 1'b1;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;
    logic       hi_en_n;
    logic [2:0] casc_mode = MODE_INC;
    logic [3:0] casc_d = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(8), .RESET_VAL(32'hA5)) dut (
        .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .d(d),
        .ser_lsb_in(ser_lsb_in), .ser_msb_in(ser_msb_in),
        .q(q), .tc(tc), .wrap(wrap)
    );

    assign hi_en_n = ~lo_tc;

    univ_reg #(.WIDTH(4), .RESET_VAL(32'h0)) u_lo (
        .clk(clk), .rst(casc_rst), .en_n(1'b0), .mode(casc_mode), .d(casc_d),
        .ser_lsb_in(1'b0), .ser_msb_in(1'b0),
        .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    univ_reg #(.WIDTH(4), .RESET_VAL(32'h0)) u_hi (
        .clk(clk), .rst(casc_rst), .en_n(hi_en_n), .mode(casc_mode), .d(casc_d),
        .ser_lsb_in(1'b0), .ser_msb_in(1'b0),
        .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_async_q: got %h expected a5", q); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_async_wrap: got %b expected 0", wrap); end
        en_n = 1'b0; mode = MODE_INC;
        tick(); tick(); tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_held_q: got %h expected a5", q); end
        rst = 1'b0;
        mode = MODE_LOAD; d = 8'hFF;
        tick();
        mode = MODE_INC;
        tick();
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL reset_setup_wrap: got %b expected 1", wrap); end
        rst = 1'b1;
        #1;
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_midcycle_q: got %h expected a5", q); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_midcycle_wrap: got %b expected 0", wrap); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_enable();
        en_n = 1'b0; mode = MODE_LOAD; d = 8'h3C;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_q: got %h expected 3c", q); end
        en_n = 1'b1; mode = MODE_INC; d = 8'h77;
        repeat (5) tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL enable_hold_q: got %h expected 3c", q); end
        en_n = 1'b0; mode = MODE_HOLD;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL hold_mode_q: got %h expected 3c", q); end
    endtask

    task automatic test_shift();
        en_n = 1'b0; mode = MODE_LOAD; d = 8'h81;
        tick();
        mode = MODE_SHL; ser_lsb_in = 1'b1; ser_msb_in = 1'b1;
        tick();
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL shl_q: got %h expected 03", q); end
        mode = MODE_SHR; ser_msb_in = 1'b0; ser_lsb_in = 1'b1;
        tick();
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL shr_q: got %h expected 01", q); end
        mode = MODE_ROR; ser_msb_in = 1'b0; ser_lsb_in = 1'b0;
        tick();
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL ror_q: got %h expected 80", q); end
        mode = MODE_ROL;
        tick();
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL rol_q: got %h expected 01", q); end
        mode = MODE_SHR; ser_msb_in = 1'b1;
        tick();
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL shr_msb1_q: got %h expected 80", q); end
        ser_msb_in = 1'b0;
    endtask

    task automatic test_count_wrap();
        en_n = 1'b0; mode = MODE_LOAD; d = 8'hFE;
        tick();
        mode = MODE_INC;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL inc_fe_tc: got %b expected 0", tc); end
        tick();
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL inc_ff_q: got %h expected ff", q); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL inc_ff_tc: got %b expected 1", tc); end
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL inc_wrap_q: got %h expected 00", q); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL inc_wrap_flag: got %b expected 1", wrap); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL inc_00_tc: got %b expected 0", tc); end
        mode = MODE_DEC;
        #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dec_00_tc: got %b expected 1", tc); end
        tick();
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dec_wrap_q: got %h expected ff", q); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dec_wrap_flag: got %b expected 1", wrap); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dec_ff_tc: got %b expected 0", tc); end
        en_n = 1'b1; mode = MODE_INC;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL disabled_tc: got %b expected 0", tc); end
        mode = MODE_LOAD; d = 8'h00;
        tick();
        checks++; if (wrap !== 1'b1 || q !== 8'hFF) begin errors++; $display("FAIL disabled_load: got q=%h wrap=%b expected q=ff wrap=1", q, wrap); end
        en_n = 1'b0; mode = MODE_ROL;
        tick();
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL rol_keeps_wrap: got %b expected 1", wrap); end
        mode = MODE_LOAD; d = 8'h00;
        tick();
        checks++; if (q !== 8'h00 || wrap !== 1'b0) begin errors++; $display("FAIL load_clears_wrap: got q=%h wrap=%b expected q=00 wrap=0", q, wrap); end
    endtask

    task automatic test_cascade();
        logic [7:0] expv;
        casc_rst = 1'b0;
        checks++; if ({hi_q, lo_q} !== 8'h00) begin errors++; $display("FAIL cascade_start: got %h expected 00", {hi_q, lo_q}); end
        for (int i = 1; i <= 256; i++) begin
            tick();
            expv = 8'(i);
            checks++;
            if ({hi_q, lo_q} !== expv) begin
                errors++;
                $display("FAIL cascade_step%0d: got %h expected %h", i, {hi_q, lo_q}, expv);
            end
        end
        casc_rst = 1'b1;
    endtask

    task automatic test_reset_mid_count();
        en_n = 1'b0; mode = MODE_LOAD; d = 8'h10;
        tick();
        mode = MODE_INC;
        tick(); tick(); tick();
        checks++; if (q !== 8'h13) begin errors++; $display("FAIL midcount_q: got %h expected 13", q); end
        rst = 1'b1;
        #1;
        checks++; if (q !== 8'hA5 || wrap !== 1'b0) begin errors++; $display("FAIL midcount_reset: got q=%h wrap=%b expected q=a5 wrap=0", q, wrap); end
        #2 rst = 1'b0;
        tick();
        checks++; if (q !== 8'hA6) begin errors++; $display("FAIL after_reset_inc: got %h expected a6", q); end
    endtask

    initial begin
        test_reset();
        test_load_enable();
        test_shift();
        test_count_wrap();
        test_cascade();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
